// File: rtl/fpu_result_buffer.sv
// fpu_result_buffer: FWFT result FIFO between the FPU and commit, with issue credits,
// sticky exception flags and a sticky overflow error.
module fpu_result_buffer #(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   issue_i,
  output logic                   can_issue_o,
  input  logic                   fpu_valid_i,
  input  logic [WIDTH-1:0]       fpu_result_i,
  input  logic [4:0]             fpu_status_i,
  input  logic [TAG_WIDTH-1:0]   fpu_tag_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [WIDTH-1:0]       out_result_o,
  output logic [4:0]             out_status_o,
  output logic [TAG_WIDTH-1:0]   out_tag_o,
  output logic [4:0]             fflags_o,
  input  logic                   fflags_clr_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d, infl_q, infl_d;
  logic [4:0]           fflags_q, fflags_d;
  logic                 ovf_q, ovf_d;
  logic [WIDTH-1:0]     res_mem [DEPTH];
  logic [4:0]           sts_mem [DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem [DEPTH];
  logic                 full, pop, push, drop, inc, dec;
  assign out_valid_o  = count_q != '0;
  assign out_result_o = res_mem[rptr_q];
  assign out_status_o = sts_mem[rptr_q];
  assign out_tag_o    = tag_mem[rptr_q];
  assign count_o      = count_q;
  assign fflags_o     = fflags_q;
  assign overflow_o   = ovf_q;
  assign can_issue_o  = ({1'b0, count_q} + {1'b0, infl_q}) < (CW + 1)'(DEPTH);
  always_comb begin
    full     = count_q == CW'(DEPTH);
    pop      = out_valid_o & out_ready_i & ~flush_i;
    push     = fpu_valid_i & ~flush_i & (~full | pop);
    drop     = fpu_valid_i & ~flush_i & full & ~pop;
    // credits saturate at both ends; a coincident issue and result cancel out
    inc      = issue_i & (~&infl_q | fpu_valid_i);
    dec      = fpu_valid_i & ((infl_q != '0) | issue_i);
    wptr_d   = flush_i ? '0 : wptr_q + AW'(push);
    rptr_d   = flush_i ? '0 : rptr_q + AW'(pop);
    count_d  = flush_i ? '0 : count_q + CW'(push) - CW'(pop);
    infl_d   = flush_i ? '0 : infl_q + CW'(inc) - CW'(dec);
    fflags_d = pop ? (fflags_clr_i ? out_status_o : fflags_q | out_status_o)
                   : (fflags_clr_i ? 5'b0 : fflags_q);
    ovf_d    = ovf_q | drop;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      infl_q   <= '0;
      fflags_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      infl_q   <= infl_d;
      fflags_q <= fflags_d;
      ovf_q    <= ovf_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      res_mem[wptr_q] <= fpu_result_i;
      sts_mem[wptr_q] <= fpu_status_i;
      tag_mem[wptr_q] <= fpu_tag_i;
    end
  end
endmodule
